// File: rtl/dsp48_mac_sched_if.sv
// Bundle of the sample, coefficient, result and DSP48 operand/control signals
// seen by dsp48_mac_sched (slave) and by the surrounding logic (master).
interface dsp48_mac_sched_if #(
    parameter int unsigned C_TAPS   = 16,
    parameter int unsigned C_DWIDTH = 18,
    parameter int unsigned C_CWIDTH = 18
);
    localparam int unsigned AW = (C_TAPS > 1) ? $clog2(C_TAPS) : 1;

    logic [C_DWIDTH-1:0] I_din;
    logic                I_din_valid;
    logic                O_din_ready;
    logic                I_coef_we;
    logic [AW-1:0]       I_coef_addr;
    logic [C_CWIDTH-1:0] I_coef_data;
    logic                O_coef_err;
    logic [29:0]         O_dsp_a;
    logic [17:0]         O_dsp_b;
    logic [7:0]          O_dsp_opmode;
    logic [4:0]          O_dsp_inmode;
    logic [3:0]          O_dsp_aluctl;
    logic [47:0]         I_dsp_p;
    logic [47:0]         O_dout;
    logic                O_dout_valid;
    logic                O_busy;

    modport slave (
        input  I_din, I_din_valid, I_coef_we, I_coef_addr, I_coef_data, I_dsp_p,
        output O_din_ready, O_coef_err, O_dsp_a, O_dsp_b, O_dsp_opmode,
               O_dsp_inmode, O_dsp_aluctl, O_dout, O_dout_valid, O_busy
    );

    modport master (
        output I_din, I_din_valid, I_coef_we, I_coef_addr, I_coef_data, I_dsp_p,
        input  O_din_ready, O_coef_err, O_dsp_a, O_dsp_b, O_dsp_opmode,
               O_dsp_inmode, O_dsp_aluctl, O_dout, O_dout_valid, O_busy
    );
endinterface

// File: rtl/dsp48_mac_sched.sv
// Time-multiplexed FIR MAC scheduler: one sample in, C_TAPS taps sequenced through
// a single DSP48E1 slice, accumulated P captured after the slice latency.
module dsp48_mac_sched #(
    parameter int unsigned C_TAPS    = 16,
    parameter int unsigned C_DWIDTH  = 18,
    parameter int unsigned C_CWIDTH  = 18,
    parameter int unsigned C_DSP_LAT = 4,
    parameter int unsigned C_OPM_DLY = 2
) (
    input logic              I_clk,
    input logic              I_rst,
    dsp48_mac_sched_if.slave bus
);
    localparam int unsigned AW = (C_TAPS > 1) ? $clog2(C_TAPS) : 1;
    localparam int unsigned CW = $clog2(C_DSP_LAT) + 1;

    localparam logic [7:0] OPM_ZERO = 8'h00;
    localparam logic [7:0] OPM_LOAD = 8'h05;
    localparam logic [7:0] OPM_ACC  = 8'h25;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       k_q, k_d;
    logic [CW-1:0]       drn_q, drn_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [C_DWIDTH-1:0] line_q [C_TAPS];
    logic [C_CWIDTH-1:0] coef_q [C_TAPS];

    logic [29:0]         a_q, a_d;
    logic [17:0]         b_q, b_d;
    logic [7:0]          tag_d;
    logic [7:0]          opm_q [C_OPM_DLY+1];
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [47:0]         dout_q;
    logic                dout_vld_q;
    logic                cerr_q, cerr_d;

    logic                accept;
    logic                dout_load;
    logic                coef_wr_ok;
    logic [AW-1:0]       rd_idx;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        drn_d     = drn_q;
        wr_ptr_d  = wr_ptr_q;
        accept    = 1'b0;
        dout_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.I_din_valid) begin
                    accept  = 1'b1;
                    k_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (k_q == AW'(C_TAPS - 1)) begin
                    drn_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drn_q == CW'(C_DSP_LAT - 1)) begin
                    dout_load = 1'b1;
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                    state_d   = S_IDLE;
                end else begin
                    drn_d = drn_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        coef_wr_ok = bus.I_coef_we && (state_q == S_IDLE);
        cerr_d     = bus.I_coef_we && (state_q != S_IDLE);
        ready_d    = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // Operands are registered from next-state values so tap k is on the pins
    // exactly in its CALC cycle; tap 0 bypasses the sample being written this
    // edge, and any tap bypasses a coefficient written this edge.
    always_comb begin
        a_d    = '0;
        b_d    = '0;
        tag_d  = OPM_ZERO;
        rd_idx = wr_ptr_q - k_d;
        if (state_d == S_CALC) begin
            if (accept) begin
                a_d = 30'($signed(bus.I_din));
            end else begin
                a_d = 30'($signed(line_q[rd_idx]));
            end
            if (coef_wr_ok && (bus.I_coef_addr == k_d)) begin
                b_d = 18'($signed(bus.I_coef_data));
            end else begin
                b_d = 18'($signed(coef_q[k_d]));
            end
            tag_d = (k_d == '0) ? OPM_LOAD : OPM_ACC;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            drn_q      <= '0;
            wr_ptr_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            cerr_q     <= 1'b0;
            for (int unsigned i = 0; i < C_TAPS; i++) begin
                line_q[i] <= '0;
                coef_q[i] <= '0;
            end
            for (int unsigned i = 0; i <= C_OPM_DLY; i++) begin
                opm_q[i] <= OPM_ZERO;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            drn_q      <= drn_d;
            wr_ptr_q   <= wr_ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            dout_vld_q <= dout_load;
            cerr_q     <= cerr_d;
            if (dout_load) begin
                dout_q <= bus.I_dsp_p;
            end
            if (accept) begin
                line_q[wr_ptr_q] <= bus.I_din;
            end
            if (coef_wr_ok) begin
                coef_q[bus.I_coef_addr] <= bus.I_coef_data;
            end
            // Stage 0 is aligned with the operand registers; the pins see the
            // tag C_OPM_DLY stages later.
            opm_q[0] <= tag_d;
            for (int unsigned i = 1; i <= C_OPM_DLY; i++) begin
                opm_q[i] <= opm_q[i-1];
            end
        end
    end

    assign bus.O_din_ready  = ready_q;
    assign bus.O_busy       = busy_q;
    assign bus.O_coef_err   = cerr_q;
    assign bus.O_dsp_a      = a_q;
    assign bus.O_dsp_b      = b_q;
    assign bus.O_dsp_opmode = opm_q[C_OPM_DLY];
    assign bus.O_dsp_inmode = 5'b00000;
    assign bus.O_dsp_aluctl = 4'b0000;
    assign bus.O_dout       = dout_q;
    assign bus.O_dout_valid = dout_vld_q;
endmodule
